// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port arbiter with long-latency result FIFO and busy scoreboard
//
// Purpose: single driver of the register-file write port (WE3/A3/WD3). The
// in-order writeback always wins the port. Long-latency results are queued
// in a small FIFO and drained on cycles without a writeback. A busy
// scoreboard tracks destinations of issued long-latency ops until their
// result leaves the FIFO.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_we, wb_rd, wb_data         pipeline writeback request
//   ll_valid, ll_ready            long-latency result handshake
//   ll_rd, ll_data                long-latency result payload
//   issue_valid, issue_rd         long-latency op issued (sets busy)
//   rs1, rs2, rs1_busy, rs2_busy  decode source registers and stall flags
//   rf_we, rf_addr, rf_data       registered register-file write port
//   fifo_count                    entries currently held in the FIFO
module regfile_write_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int FIFO_DEPTH = 2,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ll_valid,
  output logic            ll_ready,
  input  logic [AW-1:0]   ll_rd,
  input  logic [XLEN-1:0] ll_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_we,
  output logic [AW-1:0]   rf_addr,
  output logic [XLEN-1:0] rf_data,
  output logic [CW-1:0]   fifo_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [AW-1:0]     q_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]   q_data [FIFO_DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [2**AW-1:0]  busy;

  logic wb_win;
  logic push;
  logic pop;

  // ll_ready looks only at state, so a pop in the same cycle cannot free a slot.
  assign ll_ready = (fifo_count < FULL);
  assign wb_win   = wb_we && (wb_rd != '0);
  // Results aimed at x0 are handshaken but never stored.
  assign push     = ll_valid && ll_ready && (ll_rd != '0);
  // Only an entry already held may pop, so a fresh result waits one edge.
  assign pop      = !wb_win && (fifo_count != '0);

  // The value sitting on rf_* is not in the register file until the negedge,
  // so it still counts as busy for decode.
  assign rs1_busy = (rs1 != '0) && (busy[rs1] || (rf_we && (rf_addr == rs1)));
  assign rs2_busy = (rs2 != '0) && (busy[rs2] || (rf_we && (rf_addr == rs2)));

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= ll_rd;
      q_data[tail] <= ll_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      busy       <= '0;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_data    <= '0;
    end else begin
      if (wb_win) begin
        rf_we   <= 1'b1;
        rf_addr <= wb_rd;
        rf_data <= wb_data;
      end else if (pop) begin
        rf_we   <= 1'b1;
        rf_addr <= q_rd[head];
        rf_data <= q_data[head];
      end else begin
        rf_we   <= 1'b0;
      end

      if (pop) begin
        head <= (head == LAST) ? '0 : head + 1'b1;
      end
      if (push) begin
        tail <= (tail == LAST) ? '0 : tail + 1'b1;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      // Clear first, then set: a re-issue on the draining edge keeps the bit.
      if (pop) begin
        busy[q_rd[head]] <= 1'b0;
      end
      if (issue_valid && (issue_rd != '0)) begin
        busy[issue_rd] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ll_valid;
  logic            ll_ready;
  logic [AW-1:0]   ll_rd;
  logic [XLEN-1:0] ll_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rf_we;
  logic [AW-1:0]   rf_addr;
  logic [XLEN-1:0] rf_data;
  logic [CW-1:0]   fifo_count;

  regfile_write_arbiter #(.XLEN(XLEN), .AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit armed  = 0;

  // Reference model: a queue of pending results, a busy bit per register,
  // and the last value placed on the write port.
  logic [AW+XLEN-1:0] m_q[$];
  bit   [31:0]        m_busy;
  logic               m_we;
  logic [AW-1:0]      m_addr;
  logic [XLEN-1:0]    m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_busy(input logic [AW-1:0] rs);
    return (rs != 0) && (m_busy[rs] || (m_we && m_addr == rs));
  endfunction

  task automatic idle();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  // Inputs are already applied; check the visible state, advance the model
  // with those inputs, then cross one rising edge.
  task automatic cycle();
    bit wbw, pop, acc;
    logic [AW+XLEN-1:0] h;
    #1;
    if (armed) begin
      chk("rf_we", rf_we, m_we);
      if (m_we) begin
        chk("rf_addr", rf_addr, m_addr);
        chk("rf_data", rf_data, m_data);
      end
      chk("fifo_count", fifo_count, m_q.size());
      chk("ll_ready", ll_ready, m_q.size() < DEPTH);
      chk("rs1_busy", rs1_busy, exp_busy(rs1));
      chk("rs2_busy", rs2_busy, exp_busy(rs2));
    end
    if (rst) begin
      m_q.delete(); m_busy = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      wbw = wb_we && wb_rd != 0;
      acc = ll_valid && (m_q.size() < DEPTH);
      pop = !wbw && m_q.size() > 0;
      if (wbw) begin
        m_we = 1; m_addr = wb_rd; m_data = wb_data;
      end else if (pop) begin
        h = m_q.pop_front();
        m_we = 1; m_addr = h[AW+XLEN-1:XLEN]; m_data = h[XLEN-1:0];
        m_busy[m_addr] = 0;
      end else begin
        m_we = 0;
      end
      if (acc && ll_rd != 0) m_q.push_back({ll_rd, ll_data});
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
    end
    @(posedge clk);
    #1;
    armed = 1;
  endtask

  initial begin
    rst = 1; rs1 = 0; rs2 = 0;
    idle();
    cycle();
    cycle();
    rst = 0;

    // Reset state: every source register reads not-busy.
    chk("reset_rf_we", rf_we, 0);
    chk("reset_ll_ready", ll_ready, 1);
    chk("reset_count", fifo_count, 0);
    for (int i = 0; i < 32; i++) begin
      rs1 = AW'(i); rs2 = AW'(31 - i);
      #1;
      chk("reset_rs1_busy", rs1_busy, 0);
      chk("reset_rs2_busy", rs2_busy, 0);
    end

    // Plain writeback, then a writeback to x0.
    wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    cycle();
    chk("t2_we", rf_we, 1);
    chk("t2_addr", rf_addr, 5);
    chk("t2_data", rf_data, 32'hDEADBEEF);
    wb_rd = 0;
    cycle();
    chk("t2_x0_we", rf_we, 0);
    idle();

    // Issue x7, result returns three cycles later.
    rs1 = 7; rs2 = 0;
    issue_valid = 1; issue_rd = 7;
    cycle();
    issue_valid = 0;
    chk("t3_busy_after_issue", rs1_busy, 1);
    cycle();
    cycle();
    ll_valid = 1; ll_rd = 7; ll_data = 32'h1234;
    cycle();
    ll_valid = 0;
    chk("t3_no_bypass", rf_we, 0);
    cycle();
    chk("t3_we", rf_we, 1);
    chk("t3_addr", rf_addr, 7);
    chk("t3_data", rf_data, 32'h1234);
    chk("t3_busy_on_port", rs1_busy, 1);
    cycle();
    chk("t3_busy_cleared", rs1_busy, 0);

    // Four writeback cycles starve the FIFO while three results are offered.
    for (int i = 0; i < 4; i++) begin
      wb_we = 1; wb_rd = AW'(20 + i); wb_data = 32'hA000 + i;
      ll_valid = (i < 3); ll_rd = AW'(10 + i); ll_data = 32'hB000 + i;
      cycle();
    end
    idle();
    chk("t4_count", fifo_count, 2);
    chk("t4_ready", ll_ready, 0);
    cycle();
    chk("t4_first", rf_addr, 10);
    cycle();
    chk("t4_second", rf_addr, 11);
    cycle();

    // Re-issue of x9 on the edge its earlier entry pops keeps it busy.
    rs1 = 9;
    issue_valid = 1; issue_rd = 9;
    cycle();
    issue_valid = 0;
    ll_valid = 1; ll_rd = 9; ll_data = 32'h99;
    cycle();
    ll_valid = 0;
    issue_valid = 1; issue_rd = 9;
    cycle();
    issue_valid = 0;
    chk("t5_pop_addr", rf_addr, 9);
    cycle();
    chk("t5_still_busy", rs1_busy, 1);

    // Reset with a full FIFO and busy bits set.
    issue_valid = 1; issue_rd = 3;
    wb_we = 1; wb_rd = 4; wb_data = 1;
    ll_valid = 1; ll_rd = 3; ll_data = 5;
    cycle();
    cycle();
    idle();
    chk("t6_full", fifo_count, 2);
    rst = 1;
    cycle();
    rst = 0;
    rs1 = 3; rs2 = 9;
    cycle();
    chk("t6_count", fifo_count, 0);
    chk("t6_busy1", rs1_busy, 0);
    chk("t6_busy2", rs2_busy, 0);
    cycle();
    chk("t6_no_we", rf_we, 0);

    // Random traffic over a narrow register range to force collisions.
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      wb_we       = $urandom_range(0, 1);
      wb_rd       = AW'($urandom_range(0, 7));
      wb_data     = $urandom;
      ll_valid    = $urandom_range(0, 1);
      ll_rd       = AW'($urandom_range(0, 7));
      ll_data     = $urandom;
      issue_valid = $urandom_range(0, 1);
      issue_rd    = AW'($urandom_range(0, 7));
      rs1         = AW'($urandom_range(0, 7));
      rs2         = AW'($urandom_range(0, 7));
      cycle();
    end
    rst = 0;
    idle();
    for (int n = 0; n < 4; n++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
